// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and producer side of the IF/ID register.
// Single-outstanding imem fetch feeding a 2-entry {pc, inst} queue.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  hold_flag_i,
  input  logic        pip_flush,
  input  logic [31:0] flush_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_ent_t;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  fq_ent_t     fq [2];
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;

  logic full;
  logic empty;
  logic accept;
  logic push;
  logic pop;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  assign imem_req_o  = rst_n & (state == S_REQ) & ~full;
  assign imem_addr_o = pc;

  assign accept = imem_req_o & imem_ready_i;
  assign push   = (state == S_WAIT) & imem_rvalid_i & ~pip_flush;
  assign pop    = ~empty & (hold_flag_i == 3'd0) & ~pip_flush;

  assign if_valid_o = ~empty;
  assign if_pc      = empty ? 32'd0 : fq[rd_ptr].pc;
  assign if_inst    = empty ? NOP_INST : fq[rd_ptr].inst;

  // A flush retargets pc; any response still owed is routed to DROP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      req_pc <= 32'd0;
    end else begin
      if (accept) req_pc <= pc;
      if (pip_flush) pc <= flush_pc_i;
      else if (accept) pc <= pc + 32'd4;
      unique case (state)
        S_REQ: begin
          if (accept) state <= pip_flush ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) state <= S_REQ;
          else if (pip_flush) state <= S_DROP;
        end
        S_DROP: begin
          if (imem_rvalid_i) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      unique case (1'b1)
        pip_flush:    count <= 2'd0;
        push && !pop: count <= count + 2'd1;
        pop && !push: count <= count - 2'd1;
        default:      ;
      endcase
      if (pip_flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fq[wr_ptr] <= '{pc: req_pc, inst: imem_rdata_i};
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit.
// Memory returns inst = addr ^ 32'h1234 after a set latency.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [2:0]  hold_flag_i;
  logic        pip_flush;
  logic [31:0] flush_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid_o;

  int n_pass;
  int n_total;
  int mem_lat;
  int outstanding;
  logic [31:0] popped [$];

  if_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold_flag_i  (hold_flag_i),
    .pip_flush    (pip_flush),
    .flush_pc_i   (flush_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid_o   (if_valid_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic out_chk(input string tag, input logic v,
                         input logic [31:0] p, input logic [31:0] i);
    check({tag, "_valid"}, 32'(if_valid_o), 32'(v));
    check({tag, "_pc"}, if_pc, p);
    check({tag, "_inst"}, if_inst, i);
  endtask

  task automatic req_chk(input string tag, input logic r,
                         input logic [31:0] a);
    check({tag, "_req"}, 32'(imem_req_o), 32'(r));
    if (r) check({tag, "_addr"}, imem_addr_o, a);
  endtask

  // Memory: one pending response, delivered mem_lat cycles after accept.
  initial begin
    logic        acc_s;
    logic        pend;
    int          dly;
    logic [31:0] addr_s;
    logic [31:0] paddr;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    pend  = 1'b0;
    dly   = 0;
    paddr = 32'd0;
    forever begin
      @(posedge clk);
      acc_s  = rst_n & imem_req_o & imem_ready_i;
      addr_s = imem_addr_o;
      #1;
      imem_rvalid_i = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (acc_s) begin
          pend  = 1'b1;
          dly   = mem_lat;
          paddr = addr_s;
        end
        if (pend) begin
          dly--;
          if (dly <= 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = paddr ^ 32'h1234;
            pend = 1'b0;
          end
        end
      end
    end
  end

  // Pop log, pc/inst pairing, and single-outstanding monitor.
  always @(posedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      if (if_valid_o && hold_flag_i == 3'd0 && !pip_flush) begin
        popped.push_back(if_pc);
        check("pop_pair", if_inst, if_pc ^ 32'h1234);
      end
      if (imem_req_o && imem_ready_i) begin
        check("one_outstanding", 32'(outstanding), 32'd0);
        outstanding++;
      end
      if (imem_rvalid_i) outstanding--;
    end
  end

  initial begin
    logic [31:0] exp_pops [6];
    exp_pops = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008,
                 32'h8000_000C, 32'h8000_0010, 32'h8000_0100};
    n_pass       = 0;
    n_total      = 0;
    outstanding  = 0;
    mem_lat      = 1;
    rst_n        = 1'b0;
    hold_flag_i  = 3'd0;
    pip_flush    = 1'b0;
    flush_pc_i   = 32'd0;
    imem_ready_i = 1'b1;

    step(3);
    out_chk("reset", 1'b0, 32'd0, NOP);
    req_chk("reset", 1'b0, 32'd0);

    rst_n = 1'b1;
    #1 req_chk("first", 1'b1, RST_PC);
    step(2);
    out_chk("out0", 1'b1, 32'h8000_0000, 32'h8000_1234);
    req_chk("out0", 1'b1, 32'h8000_0004);
    step(1);
    out_chk("gap0", 1'b0, 32'd0, NOP);
    step(1);
    out_chk("out1", 1'b1, 32'h8000_0004, 32'h8000_1230);
    step(2);
    out_chk("out2", 1'b1, 32'h8000_0008, 32'h8000_123C);

    hold_flag_i = 3'b001;
    step(2);
    req_chk("full", 1'b0, 32'd0);
    step(8);
    out_chk("held", 1'b1, 32'h8000_0008, 32'h8000_123C);
    req_chk("held", 1'b0, 32'd0);
    hold_flag_i = 3'd0;
    step(1);
    out_chk("drain0", 1'b1, 32'h8000_000C, 32'h8000_1238);
    req_chk("drain0", 1'b1, 32'h8000_0010);
    step(1);
    out_chk("drain1", 1'b0, 32'd0, NOP);
    step(1);
    out_chk("next10", 1'b1, 32'h8000_0010, 32'h8000_1224);

    mem_lat = 3;
    step(1);
    pip_flush  = 1'b1;
    flush_pc_i = 32'h8000_0100;
    step(1);
    pip_flush = 1'b0;
    out_chk("fw_drop", 1'b0, 32'd0, NOP);
    req_chk("fw_drop", 1'b0, 32'd0);
    step(1);
    req_chk("fw_rv", 1'b0, 32'd0);
    check("fw_rv_valid", 32'(if_valid_o), 32'd0);
    step(1);
    req_chk("fw_req", 1'b1, 32'h8000_0100);
    mem_lat = 1;
    step(2);
    out_chk("fw_out", 1'b1, 32'h8000_0100, 32'h8000_1334);

    step(1);
    pip_flush  = 1'b1;
    flush_pc_i = 32'h8000_0200;
    step(1);
    pip_flush = 1'b0;
    out_chk("frv", 1'b0, 32'd0, NOP);
    req_chk("frv", 1'b1, 32'h8000_0200);
    pip_flush  = 1'b1;
    flush_pc_i = 32'h8000_0300;
    step(1);
    pip_flush = 1'b0;
    req_chk("facc", 1'b0, 32'd0);
    check("facc_valid", 32'(if_valid_o), 32'd0);
    step(1);
    req_chk("facc_req", 1'b1, 32'h8000_0300);
    step(2);
    out_chk("facc_out", 1'b1, 32'h8000_0300, 32'h8000_1134);

    pip_flush  = 1'b1;
    flush_pc_i = 32'hFFFF_FFFC;
    step(1);
    pip_flush = 1'b0;
    check("wrap_clr", 32'(if_valid_o), 32'd0);
    step(1);
    req_chk("wrap0", 1'b1, 32'hFFFF_FFFC);
    step(2);
    out_chk("wrap_out", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_EDC8);
    req_chk("wrap1", 1'b1, 32'h0000_0000);

    check("pop_count", 32'(popped.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < popped.size()) check("pop_order", popped[i], exp_pops[i]);

    mem_lat = 3;
    step(1);
    rst_n = 1'b0;
    #1 req_chk("rst_mid", 1'b0, 32'd0);
    step(1);
    out_chk("rst_mid", 1'b0, 32'd0, NOP);
    mem_lat = 1;
    step(1);
    rst_n = 1'b1;
    #1 req_chk("restart", 1'b1, RST_PC);
    step(2);
    out_chk("restart", 1'b1, 32'h8000_0000, 32'h8000_1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
